// File: rtl/spi_master_mc.sv
// spi_master_mc: full-duplex SPI master with runtime CPOL/CPHA, per-word length and one-hot CS hold.
// Optional SPI_MASTER_MC_LOOPBACK_EN adds i_loopback (rx taps MOSI internally, CS kept inactive).
module spi_master_mc #(
    parameter int unsigned CLK_DIV    = 4,
    parameter int unsigned NUM_CS     = 4,
    parameter int unsigned MAX_WIDTH  = 32,
    parameter int unsigned CS_ACT_LVL = 0,
    parameter int unsigned MSB_FIRST  = 1,
    localparam int unsigned LEN_W = $clog2(MAX_WIDTH + 1),
    localparam int unsigned SEL_W = (NUM_CS > 1) ? $clog2(NUM_CS) : 1
) (
    input  logic                 user_clk,
    input  logic                 user_rst,
    input  logic                 i_cmd_valid,
    output logic                 o_cmd_ready,
    input  logic                 i_cpol,
    input  logic                 i_cpha,
    input  logic [LEN_W-1:0]     i_len,
    input  logic [SEL_W-1:0]     i_cs_sel,
    input  logic                 i_cs_hold,
    input  logic [MAX_WIDTH-1:0] i_wr_data,
    output logic                 o_rd_valid,
    output logic [MAX_WIDTH-1:0] o_rd_data,
    output logic                 o_busy,
    output logic [NUM_CS-1:0]    o_cs,
    output logic                 o_sclk,
    output logic                 o_mosi,
`ifdef SPI_MASTER_MC_LOOPBACK_EN
    input  logic                 i_loopback,
`endif
    input  logic                 i_miso
);

    localparam int unsigned EDGE_W  = LEN_W + 1;
    localparam int unsigned DIV_W   = $clog2(CLK_DIV);
    localparam int unsigned TMO_CYC = 256 * CLK_DIV;
    localparam int unsigned TMO_W   = $clog2(TMO_CYC);

    typedef enum logic [2:0] {StIdle, StLead, StShift, StTrail, StHold} state_e;

    state_e               state_q;
    logic [DIV_W-1:0]     div_q;
    logic [TMO_W-1:0]     tmo_q;
    logic [EDGE_W-1:0]    edge_q;
    logic [LEN_W-1:0]     len_q;
    logic                 cpha_q;
    logic                 hold_q;
    logic                 gap_q;
    logic                 lb_q;
    logic [MAX_WIDTH-1:0] tx_q;
    logic [MAX_WIDTH-1:0] rx_q;
    logic [NUM_CS-1:0]    cs_act_q;
    logic [NUM_CS-1:0]    pend_cs_q;
    logic                 ready_q;
    logic                 rd_valid_q;
    logic                 busy_q;
    logic                 sclk_q;
    logic                 mosi_q;
    logic [MAX_WIDTH-1:0] rd_data_q;

    logic                 accept;
    logic [LEN_W-1:0]     cmd_len;
    logic [MAX_WIDTH-1:0] cmd_tx;
    logic [NUM_CS-1:0]    cmd_cs;
    logic                 cmd_lb;
    logic                 cmd_first;
    logic                 div_end;
    logic                 tmo_end;
    logic                 odd_edge;
    logic                 last_edge;
    logic                 do_sample;
    logic                 do_shift;
    logic                 rx_bit;
    logic                 tx_head;
    logic [MAX_WIDTH-1:0] tx_next;
    logic [MAX_WIDTH-1:0] rx_next;
    logic [MAX_WIDTH-1:0] rx_just;

    always_comb begin
        accept = i_cmd_valid && ready_q;

        cmd_len = i_len;
        if (i_len == '0) begin
            cmd_len = LEN_W'(1);
        end else if (i_len > LEN_W'(MAX_WIDTH)) begin
            cmd_len = LEN_W'(MAX_WIDTH);
        end

        // MSB-first words are left-aligned so the head bit is always tx_q[MAX_WIDTH-1]
        if (MSB_FIRST != 0) begin
            cmd_tx = i_wr_data << (MAX_WIDTH - 32'(cmd_len));
        end else begin
            cmd_tx = i_wr_data & ({MAX_WIDTH{1'b1}} >> (MAX_WIDTH - 32'(cmd_len)));
        end
        cmd_first = (MSB_FIRST != 0) ? cmd_tx[MAX_WIDTH-1] : cmd_tx[0];

        cmd_cs = '0;
        for (int i = 0; i < NUM_CS; i++) begin
            if (i_cs_sel == SEL_W'(i)) cmd_cs[i] = 1'b1;
        end
`ifdef SPI_MASTER_MC_LOOPBACK_EN
        cmd_lb = i_loopback;
`else
        cmd_lb = 1'b0;
`endif
        if (cmd_lb) cmd_cs = '0;

        div_end   = (div_q == DIV_W'(CLK_DIV - 1));
        tmo_end   = (tmo_q == TMO_W'(TMO_CYC - 1));
        odd_edge  = ~edge_q[0];
        last_edge = (edge_q == ({len_q, 1'b0} - EDGE_W'(1)));
        do_sample = (state_q == StShift) && div_end && (odd_edge != cpha_q);
        // With cpha=1 edge 1 re-drives the bit already presented at accept
        do_shift  = (state_q == StShift) && div_end && !last_edge &&
                    (cpha_q ? (odd_edge && (edge_q != '0)) : !odd_edge);

        rx_bit  = lb_q ? mosi_q : i_miso;
        tx_next = (MSB_FIRST != 0) ? (tx_q << 1) : (tx_q >> 1);
        tx_head = (MSB_FIRST != 0) ? tx_q[MAX_WIDTH-2] : tx_q[1];
        rx_next = (MSB_FIRST != 0) ? {rx_q[MAX_WIDTH-2:0], rx_bit} : {rx_bit, rx_q[MAX_WIDTH-1:1]};
        rx_just = (MSB_FIRST != 0) ? rx_q : (rx_q >> (MAX_WIDTH - 32'(len_q)));
    end

    always_ff @(posedge user_clk) begin
        if (user_rst) begin
            state_q    <= StIdle;
            div_q      <= '0;
            tmo_q      <= '0;
            edge_q     <= '0;
            len_q      <= LEN_W'(1);
            cpha_q     <= 1'b0;
            hold_q     <= 1'b0;
            gap_q      <= 1'b0;
            lb_q       <= 1'b0;
            tx_q       <= '0;
            rx_q       <= '0;
            cs_act_q   <= '0;
            pend_cs_q  <= '0;
            ready_q    <= 1'b1;
            rd_valid_q <= 1'b0;
            busy_q     <= 1'b0;
            sclk_q     <= 1'b0;
            mosi_q     <= 1'b0;
            rd_data_q  <= '0;
        end else begin
            rd_valid_q <= 1'b0;
            if (do_sample) rx_q <= rx_next;
            if (do_shift) begin
                tx_q   <= tx_next;
                mosi_q <= tx_head;
            end
            unique case (state_q)
                StIdle, StHold: begin
                    if (state_q == StHold) tmo_q <= tmo_q + 1'b1;
                    if (accept) begin
                        state_q   <= StLead;
                        ready_q   <= 1'b0;
                        busy_q    <= 1'b1;
                        div_q     <= '0;
                        edge_q    <= '0;
                        tmo_q     <= '0;
                        cpha_q    <= i_cpha;
                        len_q     <= cmd_len;
                        hold_q    <= i_cs_hold;
                        lb_q      <= cmd_lb;
                        tx_q      <= cmd_tx;
                        mosi_q    <= cmd_first;
                        rx_q      <= '0;
                        sclk_q    <= i_cpol;
                        pend_cs_q <= cmd_cs;
                        // Switching slaves mid-burst inserts a CS-inactive gap before LEAD
                        if ((state_q == StHold) && (cs_act_q != cmd_cs)) begin
                            gap_q    <= 1'b1;
                            cs_act_q <= '0;
                        end else begin
                            gap_q    <= 1'b0;
                            cs_act_q <= cmd_cs;
                        end
                    end else if ((state_q == StHold) && tmo_end) begin
                        state_q  <= StIdle;
                        busy_q   <= 1'b0;
                        cs_act_q <= '0;
                    end
                end
                StLead: begin
                    div_q <= div_q + 1'b1;
                    if (div_end) begin
                        div_q <= '0;
                        if (gap_q) begin
                            gap_q    <= 1'b0;
                            cs_act_q <= pend_cs_q;
                        end else begin
                            state_q <= StShift;
                        end
                    end
                end
                StShift: begin
                    div_q <= div_q + 1'b1;
                    if (div_end) begin
                        div_q  <= '0;
                        sclk_q <= ~sclk_q;
                        edge_q <= edge_q + 1'b1;
                        if (last_edge) state_q <= StTrail;
                    end
                end
                StTrail: begin
                    div_q <= div_q + 1'b1;
                    if (div_end) begin
                        div_q      <= '0;
                        rd_valid_q <= 1'b1;
                        rd_data_q  <= rx_just;
                        ready_q    <= 1'b1;
                        if (hold_q) begin
                            state_q <= StHold;
                            tmo_q   <= '0;
                        end else begin
                            state_q  <= StIdle;
                            busy_q   <= 1'b0;
                            cs_act_q <= '0;
                        end
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign o_cmd_ready = ready_q;
    assign o_rd_valid  = rd_valid_q;
    assign o_rd_data   = rd_data_q;
    assign o_busy      = busy_q;
    assign o_cs        = (CS_ACT_LVL != 0) ? cs_act_q : ~cs_act_q;
    assign o_sclk      = sclk_q;
    assign o_mosi      = mosi_q;

endmodule

// File: tb/tb_spi_master_mc.sv
// Directed self-checking bench for spi_master_mc: in-line SPI slave model plus rx scoreboard.
// Define SPI_MASTER_MC_LOOPBACK_EN to also exercise the loopback path.
module tb_spi_master_mc;

    localparam int CD  = 4;
    localparam int NCS = 3;

    logic        user_clk = 1'b0;
    logic        user_rst;
    logic        cmd_valid;
    logic        cmd_ready;
    logic        cpol;
    logic        cpha;
    logic [5:0]  len;
    logic [1:0]  cs_sel;
    logic        cs_hold;
    logic [31:0] wr_data;
    logic        rd_valid;
    logic [31:0] rd_data;
    logic        busy;
    logic [2:0]  cs;
    logic        sclk;
    logic        mosi;
    logic        miso;
`ifdef SPI_MASTER_MC_LOOPBACK_EN
    logic        loopback;
`endif

    int          errors = 0;
    int          checks = 0;
    logic [31:0] exp_q[$];

    always #5 user_clk = ~user_clk;

    spi_master_mc #(
        .CLK_DIV   (CD),
        .NUM_CS    (NCS),
        .MAX_WIDTH (32),
        .CS_ACT_LVL(0),
        .MSB_FIRST (1)
    ) dut (
        .user_clk   (user_clk),
        .user_rst   (user_rst),
        .i_cmd_valid(cmd_valid),
        .o_cmd_ready(cmd_ready),
        .i_cpol     (cpol),
        .i_cpha     (cpha),
        .i_len      (len),
        .i_cs_sel   (cs_sel),
        .i_cs_hold  (cs_hold),
        .i_wr_data  (wr_data),
        .o_rd_valid (rd_valid),
        .o_rd_data  (rd_data),
        .o_busy     (busy),
        .o_cs       (cs),
        .o_sclk     (sclk),
        .o_mosi     (mosi),
`ifdef SPI_MASTER_MC_LOOPBACK_EN
        .i_loopback (loopback),
`endif
        .i_miso     (miso)
    );

    initial begin
        #2_000_000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // One word: drive command, act as slave, check result. Call at a negedge; returns at the
    // negedge where rd_valid is high. lat<0 skips latency check; gap_exp = expected CS-off cycles.
    task automatic xfer(input string tag, input logic pol, input logic pha, input int ln,
                        input int sel, input logic hold, input logic [31:0] wr,
                        input logic [31:0] sword, input logic lb, input int lat,
                        input int gap_exp);
        int          leff, cyc, edges, gap, bad_cs, n, sidx, budget;
        logic [31:0] mask, got, rd_exp;
        logic [2:0]  cs_pat;
        logic        prev, cs_on;
        leff   = (ln == 0) ? 1 : ln;
        mask   = (leff == 32) ? 32'hFFFF_FFFF : ((32'd1 << leff) - 32'd1);
        cs_on  = (sel < NCS) && !lb;
        cs_pat = cs_on ? ~(3'b001 << sel) : 3'b111;
        budget = (lat >= 0) ? lat + 8 : 2000;
        cmd_valid = 1'b1;
        cpol      = pol;
        cpha      = pha;
        len       = 6'(ln);
        cs_sel    = 2'(sel);
        cs_hold   = hold;
        wr_data   = wr;
`ifdef SPI_MASTER_MC_LOOPBACK_EN
        loopback  = lb;
`endif
        miso      = sword[leff-1];
        chk({tag, " ready"}, cmd_ready, 1'b1);
        exp_q.push_back(lb ? (wr & mask) : (sword & mask));
        @(posedge user_clk);
        @(negedge user_clk);
        // Scramble inputs while busy; the latched command must be unaffected
        cmd_valid = 1'b0;
        cpol      = ~pol;
        cpha      = ~pha;
        len       = 6'($urandom_range(0, 32));
        wr_data   = $urandom;
        chk({tag, " sclk_start"}, sclk, pol);
        prev = sclk; cyc = 0; edges = 0; gap = 0; bad_cs = 0; got = '0;
        while (rd_valid !== 1'b1 && cyc < budget) begin
            if (cs === 3'b111) gap++;
            else if (cs !== cs_pat) bad_cs++;
            if (sclk !== prev) begin
                edges++;
                prev = sclk;
                n = edges;
                if (((n % 2) == 1) != pha) begin
                    got = {got[30:0], mosi};
                end else if (n < 2 * leff && (!pha || n >= 3)) begin
                    sidx = pha ? leff - 1 - (n - 1) / 2 : leff - 1 - n / 2;
                    miso = sword[sidx];
                end
            end
            @(negedge user_clk);
            cyc++;
        end
        if (rd_valid !== 1'b1) begin
            chk({tag, " rd_valid_timeout"}, rd_valid, 1'b1);
        end else begin
            if (exp_q.size() == 0) begin
                chk({tag, " scoreboard_empty"}, 1'b1, 1'b0);
            end else begin
                rd_exp = exp_q.pop_front();
                chk({tag, " rd_data"}, rd_data, rd_exp);
            end
            if (lat >= 0) chk({tag, " latency"}, cyc, lat);
            chk({tag, " sclk_edges"}, edges, 2 * leff);
            chk({tag, " mosi_bits"}, got, wr & mask);
            chk({tag, " cs_during"}, bad_cs, 0);
            chk({tag, " cs_gap"}, gap, cs_on ? gap_exp : cyc);
            chk({tag, " cs_after"}, cs, (hold && cs_on) ? cs_pat : 3'b111);
            chk({tag, " busy_after"}, busy, hold);
            chk({tag, " sclk_idle"}, sclk, pol);
        end
    endtask

    initial begin
        int n;
        user_rst  = 1'b1;
        cmd_valid = 1'b0;
        cpol      = 1'b0;
        cpha      = 1'b0;
        len       = '0;
        cs_sel    = '0;
        cs_hold   = 1'b0;
        wr_data   = '0;
        miso      = 1'b0;
`ifdef SPI_MASTER_MC_LOOPBACK_EN
        loopback  = 1'b0;
`endif
        repeat (3) @(posedge user_clk);
        @(negedge user_clk);
        chk("rst ready", cmd_ready, 1'b1);
        chk("rst rd_valid", rd_valid, 1'b0);
        chk("rst rd_data", rd_data, 32'h0);
        chk("rst busy", busy, 1'b0);
        chk("rst cs", cs, 3'b111);
        chk("rst sclk", sclk, 1'b0);
        chk("rst mosi", mosi, 1'b0);
        user_rst = 1'b0;
        @(negedge user_clk);

        // T1: mode 0, 8 bits
        xfer("t1", 1'b0, 1'b0, 8, 0, 1'b0, 32'hA5, 32'h3C, 1'b0, 72, 0);
        @(negedge user_clk);
        chk("t1 rd_valid_pulse", rd_valid, 1'b0);

        // T2: modes 1..3, 16 bits
        xfer("t2m1", 1'b0, 1'b1, 16, 1, 1'b0, 32'hBEEF, 32'hBEEF, 1'b0, 136, 0);
        xfer("t2m2", 1'b1, 1'b0, 16, 2, 1'b0, 32'hBEEF, 32'hBEEF, 1'b0, 136, 0);
        xfer("t2m3", 1'b1, 1'b1, 16, 0, 1'b0, 32'hBEEF, 32'hBEEF, 1'b0, 136, 0);
        @(negedge user_clk);

        // T3: 3-word burst on cs 2, CS held between words
        xfer("t3w0", 1'b0, 1'b0, 8, 2, 1'b1, 32'h11, 32'hC1, 1'b0, 72, 0);
        xfer("t3w1", 1'b0, 1'b0, 8, 2, 1'b1, 32'h22, 32'hC2, 1'b0, 72, 0);
        xfer("t3w2", 1'b0, 1'b0, 8, 2, 1'b0, 32'h33, 32'hC3, 1'b0, 72, 0);
        @(negedge user_clk);

        // T4: hold on cs 2, switch to cs 1 (gap), then hold timeout
        xfer("t4a", 1'b0, 1'b1, 8, 2, 1'b1, 32'h5A, 32'h81, 1'b0, 72, 0);
        xfer("t4b", 1'b0, 1'b1, 8, 1, 1'b1, 32'hC7, 32'h3E, 1'b0, -1, CD);
        n = 0;
        while (busy === 1'b1 && n < 256 * CD + 20) begin
            @(negedge user_clk);
            n++;
        end
        chk("t4 hold_timeout", n, 256 * CD);
        chk("t4 cs_released", cs, 3'b111);

        // T5: reset in the middle of SHIFT
        cmd_valid = 1'b1; cpol = 1'b1; cpha = 1'b1; len = 6'd16; cs_sel = 2'd0;
        cs_hold = 1'b0; wr_data = 32'h1234;
        @(posedge user_clk);
        @(negedge user_clk);
        cmd_valid = 1'b0;
        repeat (20) @(negedge user_clk);
        chk("t5 busy_mid", busy, 1'b1);
        user_rst = 1'b1;
        @(posedge user_clk);
        @(negedge user_clk);
        chk("t5 cs", cs, 3'b111);
        chk("t5 sclk", sclk, 1'b0);
        chk("t5 busy", busy, 1'b0);
        chk("t5 rd_valid", rd_valid, 1'b0);
        chk("t5 ready", cmd_ready, 1'b1);
        chk("t5 rd_data", rd_data, 32'h0);
        user_rst = 1'b0;
        n = 0;
        repeat (100) begin
            @(negedge user_clk);
            if (rd_valid === 1'b1) n++;
        end
        chk("t5 no_rd_valid", n, 0);
        xfer("t5post", 1'b1, 1'b1, 16, 0, 1'b0, 32'h7E81, 32'h9669, 1'b0, 136, 0);

        // T6: length and select boundaries
        xfer("t6len0", 1'b0, 1'b0, 0, 0, 1'b0, 32'hFFFF_FFFE, 32'h1, 1'b0, 16, 0);
        xfer("t6len32", 1'b0, 1'b0, 32, 1, 1'b0, 32'hDEAD_BEEF, 32'h0F1E_2D3C, 1'b0, 264, 0);
        xfer("t6upper", 1'b1, 1'b0, 12, 2, 1'b0, 32'hFFFF_F5A3, 32'hFFFF_FABC, 1'b0, 104, 0);
        xfer("t6csnone", 1'b0, 1'b0, 8, NCS, 1'b0, 32'h69, 32'h96, 1'b0, 72, 0);
`ifdef SPI_MASTER_MC_LOOPBACK_EN
        xfer("t6loop", 1'b0, 1'b0, 8, 0, 1'b0, 32'h5A, 32'hFF, 1'b1, 72, 0);
`endif
        @(negedge user_clk);
        chk("scoreboard drained", exp_q.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
